// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-port memory arbiter.
// Holds the FSM state encoding, the port-ID type and the round-robin pick helper.
package mem_arb_pkg;

   localparam int DEF_ADDR_W      = 16;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_WAIT_CYCLES = 4;
   localparam int CTR_W           = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

   typedef logic port_id_t;

   // A lone requester wins; on a tie the port that did not go last wins.
   function automatic port_id_t pick_owner(input logic req0, input logic req1,
                                           input port_id_t last_owner);
      port_id_t pick;
      if (req0 && !req1)      pick = 1'b0;
      else if (!req0 && req1) pick = 1'b1;
      else                    pick = ~last_owner;
      return pick;
   endfunction

endpackage

// File: rtl/arb_wait_ctr.sv
// Memory-latency down-counter: loaded with the wait length, counts down to 1 and stops there.
// done_o marks the final wait cycle.
module arb_wait_ctr
   import mem_arb_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CTR_W-1:0] load_val_i,
   input  logic             en_i,
   output logic [CTR_W-1:0] value_o,
   output logic             done_o
);

   logic [CTR_W-1:0] value_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         value_q <= '0;
      end else if (load_i) begin
         value_q <= load_val_i;
      end else if (en_i && (value_q > CTR_W'(1))) begin
         value_q <= value_q - CTR_W'(1);
      end
   end

   assign value_o = value_q;
   assign done_o  = (value_q == CTR_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) round-robin arbiter in front of a fixed-latency memory.
// One transaction at a time: request fields are latched in IDLE and held until DONE.
//
//   state | meaning
//   IDLE  | sample req0/req1, pick owner, latch its rw/addr/wdata
//   ISSUE | one-cycle memory strobe, load wait counter
//   WAIT  | WAIT_CYCLES cycles of memory latency, capture read data on the last
//   DONE  | one-cycle rdy pulse to the owner, record owner for round-robin
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              rw0,
   input  logic              rw1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              rdy0,
   output logic              rdy1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              mstrobe,
   output logic              mrw,
   output logic [ADDR_W-1:0] maddr,
   output logic [DATA_W-1:0] mwdata,
   input  logic [DATA_W-1:0] mrdata
);

   arb_state_e        state_q, state_d;
   port_id_t          owner_q, owner_d;
   port_id_t          last_owner_q, last_owner_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic             ctr_load;
   logic             ctr_en;
   logic             ctr_done;
   logic [CTR_W-1:0] ctr_value;

   arb_wait_ctr u_wait_ctr (
      .clk        (clk),
      .reset      (reset),
      .load_i     (ctr_load),
      .load_val_i (CTR_W'(WAIT_CYCLES)),
      .en_i       (ctr_en),
      .value_o    (ctr_value),
      .done_o     (ctr_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         rw_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         rw_q         <= rw_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      rw_d         = rw_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      ctr_load     = 1'b0;
      ctr_en       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               owner_d = pick_owner(req0, req1, last_owner_q);
               if (owner_d == 1'b0) begin
                  rw_d    = rw0;
                  addr_d  = addr0;
                  wdata_d = wdata0;
               end else begin
                  rw_d    = rw1;
                  addr_d  = addr1;
                  wdata_d = wdata1;
               end
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            ctr_load = 1'b1;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            ctr_en = 1'b1;
            if (ctr_done) begin
               if (!rw_q) rdata_d = mrdata;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            last_owner_d = owner_q;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Memory-side fields are only driven while the access is live (ISSUE/WAIT).
   logic mem_active;
   assign mem_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

   assign busy    = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_DONE);
   assign mstrobe = (state_q == ST_ISSUE);
   assign mrw     = mem_active & rw_q;
   assign maddr   = mem_active ? addr_q  : '0;
   assign mwdata  = mem_active ? wdata_q : '0;
   assign rdy0    = (state_q == ST_DONE) && (owner_q == 1'b0);
   assign rdy1    = (state_q == ST_DONE) && (owner_q == 1'b1);
   assign rdata   = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with WAIT_CYCLES=4: read, write, tie, dropped request,
// reset mid-transaction and ignored input changes.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, rw0, rw1;
   logic [15:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        rdy0, rdy1, busy, mstrobe, mrw;
   logic [31:0] rdata, mwdata, mrdata;
   logic [15:0] maddr;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_CYCLES(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .req0    (req0),
      .req1    (req1),
      .rw0     (rw0),
      .rw1     (rw1),
      .addr0   (addr0),
      .addr1   (addr1),
      .wdata0  (wdata0),
      .wdata1  (wdata1),
      .rdy0    (rdy0),
      .rdy1    (rdy1),
      .rdata   (rdata),
      .busy    (busy),
      .mstrobe (mstrobe),
      .mrw     (mrw),
      .maddr   (maddr),
      .mwdata  (mwdata),
      .mrdata  (mrdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      reset  = 1'b1;
      req0   = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
      addr0  = '0;   addr1 = '0;  wdata0 = '0; wdata1 = '0;
      mrdata = 32'h1111_1111;
      repeat (3) cyc();
      chk("rst_busy",    busy,    1'b0);
      chk("rst_mstrobe", mstrobe, 1'b0);
      chk("rst_mrw",     mrw,     1'b0);
      chk("rst_rdy0",    rdy0,    1'b0);
      chk("rst_rdy1",    rdy1,    1'b0);
      chk("rst_maddr",   maddr,   16'h0);
      chk("rst_mwdata",  mwdata,  32'h0);
      chk("rst_rdata",   rdata,   32'h0);
      reset = 1'b0;
      cyc();

      // Single read on port 0, with addr0 disturbed during WAIT
      req0 = 1'b1; rw0 = 1'b0; addr0 = 16'h0040;
      cyc(); // cycle 1
      chk("rd_c1_strobe", mstrobe, 1'b1);
      chk("rd_c1_maddr",  maddr,   16'h0040);
      chk("rd_c1_mrw",    mrw,     1'b0);
      chk("rd_c1_busy",   busy,    1'b1);
      cyc(); // cycle 2
      chk("rd_c2_strobe", mstrobe, 1'b0);
      addr0 = 16'h0FFF;
      cyc(); // cycle 3
      chk("rd_c3_maddr",  maddr,   16'h0040);
      cyc(); // cycle 4
      chk("rd_c4_maddr",  maddr,   16'h0040);
      chk("rd_c4_rdy0",   rdy0,    1'b0);
      mrdata = 32'hDEAD_BEEF;
      cyc(); // cycle 5
      chk("rd_c5_rdy0",   rdy0,    1'b0);
      chk("rd_c5_busy",   busy,    1'b1);
      cyc(); // cycle 6
      chk("rd_c6_rdy0",   rdy0,    1'b1);
      chk("rd_c6_rdy1",   rdy1,    1'b0);
      chk("rd_c6_rdata",  rdata,   32'hDEAD_BEEF);
      req0 = 1'b0; addr0 = 16'h0040; mrdata = 32'h1234_5678;
      cyc(); // cycle 7
      chk("rd_c7_rdy0",   rdy0,    1'b0);
      chk("rd_c7_busy",   busy,    1'b0);
      chk("rd_c7_rdata",  rdata,   32'hDEAD_BEEF);

      // Single write on port 1
      req1 = 1'b1; rw1 = 1'b1; addr1 = 16'h1234; wdata1 = 32'hA5A5_A5A5;
      for (int c = 1; c <= 5; c++) begin
         cyc();
         chk($sformatf("wr_c%0d_mrw", c),    mrw,     1'b1);
         chk($sformatf("wr_c%0d_mwdata", c), mwdata,  32'hA5A5_A5A5);
         chk($sformatf("wr_c%0d_maddr", c),  maddr,   16'h1234);
         chk($sformatf("wr_c%0d_strobe", c), mstrobe, (c == 1));
         chk($sformatf("wr_c%0d_rdy1", c),   rdy1,    1'b0);
      end
      cyc(); // cycle 6
      chk("wr_c6_rdy1",  rdy1,  1'b1);
      chk("wr_c6_rdy0",  rdy0,  1'b0);
      chk("wr_c6_rdata", rdata, 32'hDEAD_BEEF);
      req1 = 1'b0;
      cyc();
      chk("wr_c7_busy",  busy,  1'b0);

      // Owner drops req0 at cycle 3; transaction still completes
      req0 = 1'b1; rw0 = 1'b0; addr0 = 16'h0040;
      cyc(); // 1
      cyc(); // 2
      req0 = 1'b0;
      cyc(); // 3
      chk("drop_c3_busy", busy, 1'b1);
      cyc(); // 4
      cyc(); // 5
      chk("drop_c5_rdy0", rdy0, 1'b0);
      cyc(); // 6
      chk("drop_c6_rdy0", rdy0, 1'b1);
      cyc(); // 7
      chk("drop_c7_busy", busy, 1'b0);
      chk("drop_c7_rdy0", rdy0, 1'b0);
      cyc();
      chk("drop_c8_busy", busy, 1'b0);

      // Reset during WAIT aborts with no rdy
      req1 = 1'b1; rw1 = 1'b0; addr1 = 16'h0200;
      cyc(); // 1
      cyc(); // 2
      cyc(); // 3
      chk("rstw_c3_busy", busy, 1'b1);
      reset = 1'b1; req1 = 1'b0;
      cyc(); // 4
      chk("rstw_c4_busy",    busy,    1'b0);
      chk("rstw_c4_mstrobe", mstrobe, 1'b0);
      chk("rstw_c4_rdy1",    rdy1,    1'b0);
      chk("rstw_c4_rdata",   rdata,   32'h0);
      reset = 1'b0;
      for (int c = 5; c <= 8; c++) begin
         cyc();
         chk($sformatf("rstw_c%0d_rdy", c), {rdy0, rdy1}, 2'b00);
         chk($sformatf("rstw_c%0d_busy", c), busy, 1'b0);
      end

      // Tie after reset: grants 0,1,0,1 with rdy every 7 cycles
      req0 = 1'b1; req1 = 1'b1; rw0 = 1'b0; rw1 = 1'b1;
      addr0 = 16'h0100; addr1 = 16'h0200; wdata1 = 32'h0BAD_F00D;
      for (int c = 1; c <= 27; c++) begin
         cyc();
         chk($sformatf("tie_c%0d_rdy0", c), rdy0, (c == 6)  || (c == 20));
         chk($sformatf("tie_c%0d_rdy1", c), rdy1, (c == 13) || (c == 27));
         if (c == 1 || c == 15) chk($sformatf("tie_c%0d_maddr", c), maddr, 16'h0100);
         if (c == 8 || c == 22) chk($sformatf("tie_c%0d_maddr", c), maddr, 16'h0200);
      end
      req0 = 1'b0; req1 = 1'b0;
      cyc();
      chk("tie_end_busy", busy, 1'b0);
      cyc();
      chk("tie_end2_busy", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
